// File: rtl/pat_seq_det_if.sv
// Bundle of pattern-detector control/data signals between a driver and pat_seq_det.
// Optional pat_mask signal present only when PAT_SEQ_DET_MASK_EN is defined.
interface pat_seq_det_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  logic             data_valid;
  logic             data;
  logic             pat_load;
  logic [PAT_W-1:0] pattern;
`ifdef PAT_SEQ_DET_MASK_EN
  logic [PAT_W-1:0] pat_mask;
`endif
  logic             overlap;
  logic             cnt_clr;
  logic             flag;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
`ifdef PAT_SEQ_DET_MASK_EN
    output pat_mask,
`endif
    output data_valid, data, pat_load, pattern, overlap, cnt_clr,
    input  flag, match_cnt, cnt_sat
  );

  modport slave (
`ifdef PAT_SEQ_DET_MASK_EN
    input  pat_mask,
`endif
    input  data_valid, data, pat_load, pattern, overlap, cnt_clr,
    output flag, match_cnt, cnt_sat
  );
endinterface

// File: rtl/pat_seq_det.sv
// Serial bit-pattern detector with overlap/non-overlap modes and a saturating match counter.
// Define PAT_SEQ_DET_MASK_EN to add a per-bit don't-care mask captured alongside the pattern.
module pat_seq_det #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  pat_seq_det_if.slave bus
);
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [PAT_W-1:0]  pat_p0;
  logic [PAT_W-1:0]  mask_p0;
  logic [PAT_W-1:0]  hist_p0;
  logic [FILL_W-1:0] fill_p0;
  logic              flag_p1;
  logic [CNT_W-1:0]  cnt_p1;
  logic              sat_p1;

  logic [PAT_W-1:0]  hist_nxt;
  logic [FILL_W-1:0] fill_inc;
  logic              hit;
  logic              match;

  // stage 0: candidate history/fill including the bit offered this cycle
  always_comb begin
    hist_nxt = {hist_p0[PAT_W-2:0], bus.data};
    fill_inc = (fill_p0 == FULL) ? FULL : fill_p0 + FILL_W'(1);
    hit      = ((hist_nxt ^ pat_p0) & mask_p0) == '0;
    match    = bus.data_valid && !bus.pat_load && (fill_inc == FULL) && hit;
  end

`ifdef PAT_SEQ_DET_MASK_EN
  always_ff @(posedge clk) begin
    if (reset)             mask_p0 <= '1;
    else if (bus.pat_load) mask_p0 <= bus.pat_mask;
  end
`else
  assign mask_p0 = '1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_p0  <= '0;
      hist_p0 <= '0;
      fill_p0 <= '0;
    end else if (bus.pat_load) begin
      pat_p0  <= bus.pattern;
      hist_p0 <= '0;
      fill_p0 <= '0;
    end else if (bus.data_valid) begin
      hist_p0 <= hist_nxt;
      // non-overlap restarts the fill so the next match needs a whole fresh pattern
      fill_p0 <= (match && !bus.overlap) ? '0 : fill_inc;
    end
  end

  // stage 1: registered match pulse and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_p1 <= 1'b0;
      cnt_p1  <= '0;
      sat_p1  <= 1'b0;
    end else begin
      flag_p1 <= match;
      if (bus.cnt_clr) begin
        cnt_p1 <= '0;
        sat_p1 <= 1'b0;
      end else if (match) begin
        if (&cnt_p1) sat_p1 <= 1'b1;
        cnt_p1 <= sat_inc(cnt_p1);
      end
    end
  end

  assign bus.flag      = flag_p1;
  assign bus.match_cnt = cnt_p1;
  assign bus.cnt_sat   = sat_p1;
endmodule

// File: tb/tb_pat_seq_det.sv
// Directed table-driven bench for pat_seq_det at PAT_W=4, CNT_W=2.
// Mask streams are exercised only when PAT_SEQ_DET_MASK_EN is defined.
module tb_pat_seq_det;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pat_seq_det_if #(.PAT_W(4), .CNT_W(2)) bus ();
  pat_seq_det #(.PAT_W(4), .CNT_W(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    logic       r, dv, d, ld;
    logic [3:0] pat, msk;
    logic       ov, clr;
    logic       f;
    logic [1:0] c;
    logic       s;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;
  int row     = 0;
  vec_t tbl[$];

  function automatic vec_t v(input logic r, dv, d, ld, input logic [3:0] pat,
                             input logic ov, clr, f, input logic [1:0] c, input logic s);
    vec_t t;
    t.r = r; t.dv = dv; t.d = d; t.ld = ld; t.pat = pat; t.msk = 4'hF;
    t.ov = ov; t.clr = clr; t.f = f; t.c = c; t.s = s;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at step %0d: got %0d, want %0d", name, idx, act, exp);
  endtask

  task automatic apply(input vec_t t);
    @(negedge clk);
    reset          = t.r;
    bus.data_valid = t.dv;
    bus.data       = t.d;
    bus.pat_load   = t.ld;
    bus.pattern    = t.pat;
    bus.overlap    = t.ov;
    bus.cnt_clr    = t.clr;
`ifdef PAT_SEQ_DET_MASK_EN
    bus.pat_mask   = t.msk;
`endif
    @(posedge clk);
    #1;
    chk("flag", row, int'(bus.flag), int'(t.f));
    chk("match_cnt", row, int'(bus.match_cnt), int'(t.c));
    chk("cnt_sat", row, int'(bus.cnt_sat), int'(t.s));
    row++;
  endtask

  // helper for a plain data bit: no load, no clear
  function automatic vec_t b(input logic d, ov, f, input logic [1:0] c, input logic s);
    return v(1'b0, 1'b1, d, 1'b0, 4'h0, ov, 1'b0, f, c, s);
  endfunction

  function automatic vec_t gap(input logic ov, input logic [1:0] c, input logic s);
    return v(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, ov, 1'b0, 1'b0, c, s);
  endfunction

  initial begin
    reset = 1'b1; bus.data_valid = 1'b0; bus.data = 1'b0; bus.pat_load = 1'b0;
    bus.pattern = '0; bus.overlap = 1'b0; bus.cnt_clr = 1'b0;
`ifdef PAT_SEQ_DET_MASK_EN
    bus.pat_mask = '1;
`endif
    // overlap on, pattern 1011, stream 1011011
    tbl.push_back(v(1, 0, 0, 0, 4'h0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 4'hB, 1, 0, 0, 0, 0));
    tbl.push_back(b(1, 1, 0, 0, 0)); tbl.push_back(b(0, 1, 0, 0, 0));
    tbl.push_back(b(1, 1, 0, 0, 0)); tbl.push_back(b(1, 1, 1, 1, 0));
    tbl.push_back(b(0, 1, 0, 1, 0)); tbl.push_back(b(1, 1, 0, 1, 0));
    tbl.push_back(b(1, 1, 1, 2, 0));
    // overlap off, same stream
    tbl.push_back(v(0, 0, 0, 1, 4'hB, 0, 1, 0, 0, 0));
    tbl.push_back(b(1, 0, 0, 0, 0)); tbl.push_back(b(0, 0, 0, 0, 0));
    tbl.push_back(b(1, 0, 0, 0, 0)); tbl.push_back(b(1, 0, 1, 1, 0));
    tbl.push_back(b(0, 0, 0, 1, 0)); tbl.push_back(b(1, 0, 0, 1, 0));
    tbl.push_back(b(1, 0, 0, 1, 0));
    // 1111 with gaps, overlap on; counter saturates, then clear with a 5th match
    tbl.push_back(v(0, 0, 0, 1, 4'hF, 1, 1, 0, 0, 0));
    tbl.push_back(b(1, 1, 0, 0, 0)); tbl.push_back(gap(1, 0, 0));
    tbl.push_back(b(1, 1, 0, 0, 0)); tbl.push_back(b(1, 1, 0, 0, 0));
    tbl.push_back(gap(1, 0, 0));     tbl.push_back(b(1, 1, 1, 1, 0));
    tbl.push_back(gap(1, 1, 0));     tbl.push_back(b(1, 1, 1, 2, 0));
    tbl.push_back(b(1, 1, 1, 3, 0)); tbl.push_back(b(1, 1, 1, 3, 1));
    tbl.push_back(v(0, 1, 1, 0, 4'h0, 1, 1, 1, 0, 0));
    tbl.push_back(gap(1, 0, 0));
    // 1111 with gaps, overlap off
    tbl.push_back(v(0, 0, 0, 1, 4'hF, 0, 1, 0, 0, 0));
    tbl.push_back(b(1, 0, 0, 0, 0)); tbl.push_back(gap(0, 0, 0));
    tbl.push_back(b(1, 0, 0, 0, 0)); tbl.push_back(b(1, 0, 0, 0, 0));
    tbl.push_back(b(1, 0, 1, 1, 0)); tbl.push_back(gap(0, 1, 0));
    tbl.push_back(b(1, 0, 0, 1, 0)); tbl.push_back(b(1, 0, 0, 1, 0));
    tbl.push_back(b(1, 0, 0, 1, 0));
    // after reset the stored pattern is 0000: needs four accepted bits
    tbl.push_back(v(1, 1, 1, 1, 4'hF, 1, 0, 0, 0, 0));
    tbl.push_back(b(0, 1, 0, 0, 0)); tbl.push_back(b(0, 1, 0, 0, 0));
    tbl.push_back(b(0, 1, 0, 0, 0)); tbl.push_back(b(0, 1, 1, 1, 0));
    // reset mid-sequence, then a full pattern after reload
    tbl.push_back(v(0, 0, 0, 1, 4'hB, 1, 1, 0, 0, 0));
    tbl.push_back(b(1, 1, 0, 0, 0)); tbl.push_back(b(0, 1, 0, 0, 0));
    tbl.push_back(b(1, 1, 0, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 4'h0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 4'hB, 1, 0, 0, 0, 0));
    tbl.push_back(b(1, 1, 0, 0, 0)); tbl.push_back(b(0, 1, 0, 0, 0));
    tbl.push_back(b(1, 1, 0, 0, 0)); tbl.push_back(b(1, 1, 1, 1, 0));
    // load together with a valid bit: the bit is dropped
    tbl.push_back(v(0, 1, 1, 1, 4'hB, 1, 1, 0, 0, 0));
    tbl.push_back(b(0, 1, 0, 0, 0)); tbl.push_back(b(1, 1, 0, 0, 0));
    tbl.push_back(b(1, 1, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // overlap switched mid-run: takes effect on the next accepted bit
    apply(v(0, 0, 0, 1, 4'hF, 1, 1, 0, 0, 0));
    apply(b(1, 1, 0, 0, 0)); apply(b(1, 1, 0, 0, 0)); apply(b(1, 1, 0, 0, 0));
    apply(b(1, 1, 1, 1, 0));
    apply(b(1, 0, 1, 2, 0));
    apply(b(1, 0, 0, 2, 0));
    apply(b(1, 1, 0, 2, 0));
    apply(b(1, 1, 0, 2, 0));
    apply(b(1, 1, 1, 3, 0));

`ifdef PAT_SEQ_DET_MASK_EN
    begin
      logic [3:0] streams [4];
      logic       want    [4];
      vec_t       t;
      streams[0] = 4'b1001; want[0] = 1'b1;
      streams[1] = 4'b1111; want[1] = 1'b1;
      streams[2] = 4'b1011; want[2] = 1'b1;
      streams[3] = 4'b0001; want[3] = 1'b0;
      for (int s = 0; s < 4; s++) begin
        t = v(0, 0, 0, 1, 4'b1001, 1, 1, 0, 0, 0);
        t.msk = 4'b1001;
        apply(t);
        for (int k = 3; k >= 1; k--) apply(b(streams[s][k], 1, 0, 0, 0));
        apply(b(streams[s][0], 1, want[s], {1'b0, want[s]}, 0));
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pat_seq_det.md
PAT_SEQ_DET -- requirements
Module: pat_seq_det

Interface
REQ-001 SHALL have parameter PAT_W, default 8, pattern length in bits (2..32).
REQ-002 SHALL have parameter CNT_W, default 8, match-counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_valid  input  1  data is sampled this cycle.
REQ-006 SHALL have port data  input  1  serial input bit.
REQ-007 SHALL have port pat_load  input  1  capture pattern into internal register.
REQ-008 SHALL have port pattern  input  PAT_W  target sequence; MSB is the first bit received.
REQ-009 SHALL have port overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 SHALL have port cnt_clr  input  1  clear match counter and saturation flag.
REQ-011 SHALL have port flag  output  1  registered one-cycle match pulse.
REQ-012 SHALL have port match_cnt  output  CNT_W  number of matches since last clear.
REQ-013 SHALL have port cnt_sat  output  1  sticky: counter has saturated.

Function
REQ-014 SHALL keep a PAT_W-bit history register; on data_valid, shift left and insert data at LSB.
REQ-015 SHALL keep a fill counter, incremented on each accepted bit, saturating at PAT_W.
REQ-016 SHALL declare a match when fill counter is PAT_W (counting the bit accepted this cycle) and the updated history equals the stored pattern.
REQ-017 SHALL assert flag for exactly one cycle, in the cycle after the edge that accepted the completing bit; flag is 0 in every other cycle, including cycles with data_valid=0.
REQ-018 Overlap mode: after a match, history and fill are retained; the next match can complete on the next accepted bit.
REQ-019 Non-overlap mode: after a match, fill is cleared to 0; the next match requires PAT_W newly accepted bits.
REQ-020 overlap SHALL be sampled per accepted bit; a change takes effect on the next accepted bit.
REQ-021 pat_load SHALL capture pattern, clear history and fill, and suppress flag on the following cycle.
REQ-022 pat_load with data_valid in the same cycle: load wins; the data bit is discarded.
REQ-023 SHALL increment match_cnt on each match; at all-ones it holds, and cnt_sat is set on the first match attempted while saturated.
REQ-024 cnt_clr SHALL zero match_cnt and cnt_sat; cnt_clr coincident with a match leaves match_cnt=0 (match not counted) while flag still pulses.
REQ-025 data_valid=0 cycles SHALL leave history, fill and counters unchanged.

Reset
REQ-026 On reset=1 at a rising edge: flag=0, match_cnt=0, cnt_sat=0, history=0, fill=0, stored pattern=0.
REQ-027 Reset SHALL override all other inputs in that cycle; asserted mid-sequence, it discards partial progress, and no flag is produced in the cycle after reset.
REQ-028 After reset, no match SHALL be possible until PAT_W bits have been accepted, even if the pattern is all zeros.

Configuration
REQ-029 Macro PAT_SEQ_DET_MASK_EN, when defined, SHALL add input pat_mask (PAT_W), captured with pattern on pat_load; bits with mask=0 are don't-care in the compare; reset value of the stored mask is all ones.
REQ-030 Without PAT_SEQ_DET_MASK_EN, the pat_mask port SHALL be absent and the compare SHALL be exact on all PAT_W bits.

Verification
REQ-031 PAT_W=4, load 1011, overlap=1, stream 1,0,1,1,0,1,1 -> flag pulses after bits 4 and 7; match_cnt=2.
REQ-032 Same with overlap=0 -> one flag after bit 4 only; match_cnt=1.
REQ-033 PAT_W=4, pattern 1111, stream seven 1s with data_valid gaps inserted -> overlap=1: 4 flags; overlap=0: 1 flag; gaps never cause a flag.
REQ-034 CNT_W=2, force 4 matches -> match_cnt holds 3 and cnt_sat=1; cnt_clr coincident with a 5th match -> match_cnt=0, cnt_sat=0, flag=1.
REQ-035 Reset after 3 of 4 pattern bits -> no flag on the 4th bit; a full 4-bit pattern afterwards produces a flag; pat_load with data_valid in the same cycle drops the bit.
REQ-036 With PAT_SEQ_DET_MASK_EN, pattern 1001, mask 1001 -> streams 1001, 1111 and 1011 each produce a flag; 0001 does not.
